// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller between ID and EX.
// Shadows EX/MEM occupants and emits registered ALU operand mux selects.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_R0     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  output logic                  stall_id,
  output logic                  ex_valid,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  logic exs_valid;
  reg_t exs_dest;
  logic exs_regwrite;
  logic exs_memread;

  logic mems_valid;
  reg_t mems_dest;
  logic mems_regwrite;

  logic ex_hit_rs;
  logic ex_hit_rt;
  logic mem_hit_rs;
  logic mem_hit_rt;
  logic lu;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Register 0 is hard-wired unless forwarding of it is enabled.
  function automatic logic hit(
    input reg_t src,
    input logic rd,
    input logic v,
    input reg_t d,
    input logic rw
  );
    return rd && v && rw && (d == src) && (FWD_R0 || (src != '0));
  endfunction

  // Producer matches and the load-use condition against pre-edge shadows.
  always_comb begin
    ex_hit_rs  = hit(id_rs, id_use_rs, exs_valid, exs_dest, exs_regwrite);
    ex_hit_rt  = hit(id_rt, id_use_rt, exs_valid, exs_dest, exs_regwrite);
    mem_hit_rs = hit(id_rs, id_use_rs, mems_valid, mems_dest, mems_regwrite);
    mem_hit_rt = hit(id_rt, id_use_rt, mems_valid, mems_dest, mems_regwrite);
    lu = id_valid && exs_valid && exs_memread && (ex_hit_rs || ex_hit_rt);
    stall_id = !rst && (ext_stall || (lu && !flush));
  end

  // Newest producer wins; idle ID slot reads the register file.
  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    if (id_valid) begin
      if (ex_hit_rs)       sel_a = SEL_EXM;
      else if (mem_hit_rs) sel_a = SEL_MWB;
      if (ex_hit_rt)       sel_b = SEL_EXM;
      else if (mem_hit_rt) sel_b = SEL_MWB;
    end
  end

  // Shadow pipeline advance with rst > ext_stall > flush/load-use > normal.
  always_ff @(posedge clk) begin
    if (rst) begin
      exs_valid     <= 1'b0;
      exs_dest      <= '0;
      exs_regwrite  <= 1'b0;
      exs_memread   <= 1'b0;
      mems_valid    <= 1'b0;
      mems_dest     <= '0;
      mems_regwrite <= 1'b0;
      ex_valid      <= 1'b0;
      fwd_a_sel     <= SEL_RF;
      fwd_b_sel     <= SEL_RF;
    end else if (!ext_stall) begin
      mems_valid    <= exs_valid;
      mems_dest     <= exs_dest;
      mems_regwrite <= exs_regwrite;
      if (flush || lu) begin
        exs_valid    <= 1'b0;
        exs_regwrite <= 1'b0;
        exs_memread  <= 1'b0;
        ex_valid     <= 1'b0;
        fwd_a_sel    <= SEL_RF;
        fwd_b_sel    <= SEL_RF;
      end else begin
        exs_valid    <= id_valid;
        exs_dest     <= id_dest;
        exs_regwrite <= id_regwrite;
        exs_memread  <= id_memread;
        ex_valid     <= id_valid;
        fwd_a_sel    <= sel_a;
        fwd_b_sel    <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Testbench for fwd_hazard_ctrl: directed vector table then random
// traffic checked against a producer-distance reference model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, ext_stall, flush, id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic       stall_id, ex_valid;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .FWD_R0(1'b0)) dut (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .stall_id(stall_id),
    .ex_valid(ex_valid), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  typedef struct {
    bit rst, xs, fl, iv;
    bit [4:0] rs, rt;
    bit urs, urt;
    bit [4:0] dest;
    bit rw, mr;
    bit e_st, e_v;
    bit [1:0] e_a, e_b;
  } vec_t;

  // Reference model: the two older in-flight producers, [0] nearest.
  typedef struct {
    bit v;
    bit [4:0] d;
    bit rw;
    bit mr;
  } prod_t;

  prod_t pipe[2];
  bit       m_st, m_v;
  bit [1:0] m_a, m_b;

  function automatic bit writes(prod_t p, bit [4:0] s, bit u);
    return u && p.v && p.rw && p.d == s && s != 0;
  endfunction

  function automatic bit [1:0] dist_sel(bit [4:0] s, bit u);
    for (int d = 0; d < 2; d++)
      if (writes(pipe[d], s, u)) return 2'(d + 1);
    return 2'b00;
  endfunction

  task automatic model_cycle();
    bit hz;
    prod_t nw;
    hz = id_valid && pipe[0].v && pipe[0].mr &&
         (writes(pipe[0], id_rs, id_use_rs) ||
          writes(pipe[0], id_rt, id_use_rt));
    m_st = !rst && (ext_stall || (hz && !flush));
    if (rst) begin
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};
      m_v = 0; m_a = 0; m_b = 0;
    end else if (!ext_stall) begin
      nw = '{v: id_valid, d: id_dest, rw: id_regwrite, mr: id_memread};
      if (flush || hz) begin
        nw = '{default: 0};
        m_v = 0; m_a = 0; m_b = 0;
      end else begin
        m_v = id_valid;
        m_a = id_valid ? dist_sel(id_rs, id_use_rs) : 2'b00;
        m_b = id_valid ? dist_sel(id_rt, id_use_rt) : 2'b00;
      end
      pipe[1] = pipe[0];
      pipe[0] = nw;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit tbl, input string tag);
    rst = v.rst; ext_stall = v.xs; flush = v.fl; id_valid = v.iv;
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
    id_dest = v.dest; id_regwrite = v.rw; id_memread = v.mr;
    @(negedge clk);
    model_cycle();
    chk({tag, " stall"}, int'(stall_id), tbl ? int'(v.e_st) : int'(m_st));
    @(posedge clk);
    #1;
    chk({tag, " exv"}, int'(ex_valid), tbl ? int'(v.e_v) : int'(m_v));
    chk({tag, " sel_a"}, int'(fwd_a_sel), tbl ? int'(v.e_a) : int'(m_a));
    chk({tag, " sel_b"}, int'(fwd_b_sel), tbl ? int'(v.e_b) : int'(m_b));
  endtask

  function automatic vec_t mk(
    bit r, bit xs, bit fl, bit iv, int rs, int rt, bit urs, bit urt,
    int dest, bit rw, bit mr, bit st, bit ev, int a, int b);
    vec_t v;
    v.rst = r; v.xs = xs; v.fl = fl; v.iv = iv;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt;
    v.dest = 5'(dest); v.rw = rw; v.mr = mr;
    v.e_st = st; v.e_v = ev; v.e_a = 2'(a); v.e_b = 2'(b);
    return v;
  endfunction

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst = 1; ext_stall = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dest = 0; id_regwrite = 0; id_memread = 0;
    pipe[0] = '{default: 0};
    pipe[1] = '{default: 0};
    m_v = 0; m_a = 0; m_b = 0;

    //          r xs fl iv rs rt u u dst rw mr | st v a b
    tbl.push_back(mk(1,1,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,2,1,1, 3,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 3,4,1,1, 5,1,0, 0,1,1,0));
    tbl.push_back(mk(0,0,0,1, 1,2,1,1, 3,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 3,3,1,1, 6,1,0, 0,1,2,2));
    tbl.push_back(mk(0,0,0,1, 1,2,1,1, 3,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 1,2,1,1, 3,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 3,3,1,1, 6,1,0, 0,1,1,1));
    tbl.push_back(mk(0,0,0,1, 1,0,1,0, 7,1,1, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 7,2,1,1, 8,1,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,1, 7,2,1,1, 8,1,0, 0,1,2,0));
    tbl.push_back(mk(0,0,0,1, 1,2,1,1, 0,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,1,1, 9,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 1,0,1,0, 0,1,1, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,1,1,10,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 1,0,1,0, 7,1,1, 0,1,0,0));
    tbl.push_back(mk(0,0,1,1, 7,2,1,1,11,1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 7,2,1,1,11,1,0, 0,1,2,0));
    tbl.push_back(mk(0,0,0,1, 1,2,1,1, 3,1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 3,4,1,1, 5,1,0, 0,1,1,0));
    tbl.push_back(mk(0,1,0,1, 5,3,1,1, 6,1,0, 1,1,1,0));
    tbl.push_back(mk(0,1,0,1, 5,3,1,1, 6,1,0, 1,1,1,0));
    tbl.push_back(mk(0,1,0,1, 5,3,1,1, 6,1,0, 1,1,1,0));
    tbl.push_back(mk(0,0,0,1, 5,3,1,1, 6,1,0, 0,1,1,2));
    tbl.push_back(mk(0,0,0,1, 1,0,1,0, 7,1,1, 0,1,0,0));
    tbl.push_back(mk(0,0,0,1, 7,2,1,1, 8,1,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,1, 7,2,1,1, 8,1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 7,2,1,1, 8,1,0, 0,1,0,0));

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("v%0d", i));

    for (int n = 0; n < 600; n++) begin
      rv.rst  = ($urandom_range(0, 39) == 0);
      rv.xs   = ($urandom_range(0, 5) == 0);
      rv.fl   = ($urandom_range(0, 7) == 0);
      rv.iv   = ($urandom_range(0, 3) != 0);
      rv.rs   = 5'($urandom_range(0, 5));
      rv.rt   = 5'($urandom_range(0, 5));
      rv.urs  = ($urandom_range(0, 4) != 0);
      rv.urt  = ($urandom_range(0, 4) != 0);
      rv.dest = 5'($urandom_range(0, 5));
      rv.rw   = ($urandom_range(0, 4) != 0);
      rv.mr   = ($urandom_range(0, 2) == 0);
      rv.e_st = 0; rv.e_v = 0; rv.e_a = 0; rv.e_b = 0;
      step(rv, 1'b0, $sformatf("r%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Registered forwarding and hazard controller for the 5-stage integer pipeline.
- Sits between ID and EX. Each cycle it looks at the instruction leaving ID and shadows the EX and MEM stage occupants.
- Drives the 2-bit select of the two 3-input ALU-operand muxes: 00 = ID/EX register-file value, 01 = EX/MEM result, 10 = MEM/WB result, 11 = zero.
- Generates the load-use stall and bubble.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- FWD_R0, 0, when 1, register 0 may be forwarded; when 0, register 0 never matches.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- ext_stall  input  1  global freeze (memory wait); holds all state
- flush  input  1  branch/jump resolved taken; kills the instruction currently in ID
- id_valid  input  1  ID holds a real instruction
- id_rs  input  REG_ADDR_W  source A specifier
- id_rt  input  REG_ADDR_W  source B specifier
- id_use_rs  input  1  instruction reads rs
- id_use_rt  input  1  instruction reads rt
- id_dest  input  REG_ADDR_W  destination specifier of ID instruction
- id_regwrite  input  1  ID instruction writes id_dest
- id_memread  input  1  ID instruction is a load
- stall_id  output  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  output  1  EX holds a real instruction (registered)
- fwd_a_sel  output  2  ALU operand A mux select, valid during EX (registered)
- fwd_b_sel  output  2  ALU operand B mux select, valid during EX (registered)

Behaviour:
- Internal shadow stages:
  - EXs = {valid, dest, regwrite, memread}.
  - MEMs = {valid, dest, regwrite}.
- Reset (rst=1 at edge):
  - EXs.valid and MEMs.valid cleared.
  - ex_valid=0, fwd_a_sel=00, fwd_b_sel=00.
  - stall_id=0 for the whole cycle rst is high.
- Match function m(src, use, stage):
  - Requires use & stage.valid & stage.regwrite & stage.dest==src.
  - Also requires src!=0, unless FWD_R0=1.
- Load-use condition lu:
  - id_valid & EXs.valid & EXs.memread.
  - And (m(id_rs,id_use_rs,EXs) | m(id_rt,id_use_rt,EXs)).
  - The zero-register rule applies.
- stall_id = ext_stall | (lu & !flush).
- Edge update priority: rst > ext_stall > flush > lu > normal.
  - ext_stall: every register holds its value, including selects and ex_valid.
  - flush:
    - MEMs <= EXs.
    - EXs <= bubble (valid 0).
    - ex_valid <= 0, selects <= 00.
  - lu:
    - MEMs <= EXs.
    - EXs <= bubble.
    - ex_valid <= 0, selects <= 00.
    - ID instruction is re-presented next cycle; its rerun sees the load in MEMs and gets select 10.
  - normal:
    - MEMs <= EXs.
    - EXs <= ID fields, with valid=id_valid.
    - ex_valid <= id_valid.
- Select computation (normal advance only), evaluated against pre-edge EXs and MEMs, which become MEM and WB:
  - Operand A: 01 if m(id_rs,id_use_rs,EXs); else 10 if m(id_rs,id_use_rs,MEMs); else 00.
  - Operand B: same, using id_rt/id_use_rt.
  - Newest producer wins: 01 beats 10 when both match.
  - If id_valid=0, selects=00.
  - This block never emits 11.
- The register file writes before it reads in the same cycle, so producers three or more stages older need no forwarding.
- Latency: a select is produced one cycle after the consumer sits in ID. It is stable for the whole EX cycle.
- Stall is combinational. It must not depend on fwd_*_sel, to avoid loops.
- Reset mid-stall: the shadow stages clear, so the held instruction re-enters as if with no producers.

Test Plan:
- Back-to-back dependency: ADD r3 (dest 3, regwrite) then SUB r5,r3,r4 (rs=3, rt=4) -> no stall; in SUB's EX cycle fwd_a_sel=01, fwd_b_sel=00, ex_valid=1.
- Distance-2 and double match:
  - ADD r3; NOP; OR r6,r3,r3 -> both selects=10.
  - ADD r3; ADD r3; OR r6,r3,r3 -> both selects=01 (priority).
- Load-use: LW r7 then ADD r8,r7,r2 -> stall_id=1 for exactly 1 cycle; next cycle ex_valid=0 with selects 00; following cycle fwd_a_sel=10, ex_valid=1.
- Register zero: ADD r0 then AND r9,r0,r0 with FWD_R0=0 -> selects 00; LW r0 then a use of r0 -> no stall.
- Flush vs load-use: LW r7, consumer of r7 in ID, flush=1 same cycle -> stall_id=0; EX bubble next cycle; shadow MEMs holds the load.
- ext_stall and reset:
  - Assert ext_stall for 3 cycles mid-dependency -> selects and ex_valid frozen, stall_id=1; they resume unchanged after release.
  - Assert rst during a load-use stall -> next cycle all outputs 0 and stall_id=0.
